if_fetch_unit: RTL

- Instruction fetch front end; the consumer side of the PC register.
- Reads the current PC, issues reads to a synchronous instruction memory, and drives the PC's enable and next-value inputs.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles redirect/flush from branch resolution and a halt request from the debug unit.

---
 rtl/if_fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction fetch front end. Sits on the consumer side of the PC register:
// it reads the current PC, issues reads to a synchronous (one-cycle latency)
// instruction memory, steers the PC register's load enable / next value, and
// buffers returned words in a small FIFO that decode drains with valid/ready.
//
// A credit scheme (in-flight read + FIFO occupancy <= DEPTH) guarantees that
// every issued read has a FIFO slot waiting for it, so the FIFO never
// overflows and memory never has to be stalled.
//
// Ports
//   clk           clock
//   i_rst         synchronous active-high reset
//   i_pc          current PC from the PC register
//   o_pc_next     next PC value (redirect target or PC+4)
//   o_pc_en       PC register load enable
//   o_imem_rd     instruction memory read request
//   o_imem_addr   instruction memory read address (= i_pc)
//   i_imem_data   read data, valid the cycle after o_imem_rd
//   o_valid       FIFO head holds an instruction for decode
//   o_instr       instruction word at the FIFO head
//   o_instr_pc    PC of the instruction at the FIFO head
//   i_ready       decode accepts the head entry
//   i_flush       redirect request (from branch resolution)
//   i_flush_pc    redirect target
//   i_halt        stop issuing new fetches (debug)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
   parameter int NB_PC    = 32,
   parameter int NB_INSTR = 32,
   parameter int DEPTH    = 2
) (
   input  logic                clk,
   input  logic                i_rst,
   input  logic [NB_PC-1:0]    i_pc,
   output logic [NB_PC-1:0]    o_pc_next,
   output logic                o_pc_en,
   output logic                o_imem_rd,
   output logic [NB_PC-1:0]    o_imem_addr,
   input  logic [NB_INSTR-1:0] i_imem_data,
   output logic                o_valid,
   output logic [NB_INSTR-1:0] o_instr,
   output logic [NB_PC-1:0]    o_instr_pc,
   input  logic                i_ready,
   input  logic                i_flush,
   input  logic [NB_PC-1:0]    i_flush_pc,
   input  logic                i_halt
);

   localparam int AW = $clog2(DEPTH);
   // Wide enough to hold DEPTH plus the in-flight read without wrapping.
   localparam int CW = $clog2(DEPTH) + 2;

   // FIFO storage (data only, never reset)
   logic [NB_INSTR-1:0] instr_mem [DEPTH];
   logic [NB_PC-1:0]    pc_mem    [DEPTH];

   // FIFO control
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   // Read-request stage: request issued last cycle, its PC, and kill marker
   logic             vld_p1;
   logic             kill_p1;
   logic [NB_PC-1:0] pc_p1;

   logic          pop;
   logic          push;
   logic          issue;
   logic [CW-1:0] credit_used;

   // ---------------- stage p0: issue / PC control / handshake ----------------
   always_comb begin
      o_valid     = ~i_rst & (count != '0);
      pop         = o_valid & i_ready & ~i_flush;
      // pop implies count >= 1, so this subtraction cannot underflow.
      credit_used = CW'(vld_p1) + count - CW'(pop);
      issue       = ~i_rst & ~i_halt & ~i_flush & (credit_used < CW'(DEPTH));
      // A flush discards both the word landing now and the one marked by kill.
      push        = vld_p1 & ~kill_p1 & ~i_flush;

      o_imem_rd   = issue;
      o_imem_addr = i_pc;
      o_pc_en     = issue | (i_flush & ~i_rst);
      o_pc_next   = i_flush ? i_flush_pc : (i_pc + NB_PC'(4));

      o_instr     = instr_mem[rd_ptr];
      o_instr_pc  = pc_mem[rd_ptr];
   end

   // ---------------- stage p1: memory response / FIFO update ----------------
   always_ff @(posedge clk) begin
      if (i_rst) begin
         vld_p1  <= 1'b0;
         kill_p1 <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         vld_p1  <= issue;
         kill_p1 <= i_flush;
         if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Datapath registers: PC captured at issue, FIFO write on push.
   always_ff @(posedge clk) begin
      if (issue) pc_p1 <= i_pc;
      if (push) begin
         instr_mem[wr_ptr] <= i_imem_data;
         pc_mem[wr_ptr]    <= pc_p1;
      end
   end

endmodule
